// File: rtl/uart_reg_pkg.sv
// uart_reg_pkg: register map, flag bit positions and FSM states shared by the UART bus initiator.
package uart_reg_pkg;
    localparam logic [3:0] UART_ADDR_FLAGS = 4'd0;
    localparam logic [3:0] UART_ADDR_DATA  = 4'd8;
    localparam logic [3:0] UART_ADDR_DIV   = 4'd12;
    localparam int FLAG_TX_READY = 0;
    localparam int FLAG_RX_READY = 1;
    typedef enum logic [2:0] {INIT, POLL, DECIDE, RXRD, TXWR} state_e;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: first-word fall-through synchronous FIFO with async active-low flush.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] cnt_q;
    logic do_push, do_pop;
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == FULL;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem[rd_q];
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= data_i;
    end
endmodule

// File: rtl/uart_reg_initiator.sv
// uart_reg_initiator: programs the UART divider, then polls flags and shuttles bytes between FIFOs and the UART.
// Optional UART_REG_INITIATOR_ECHO_EN: received bytes are also queued for transmission.
module uart_reg_initiator import uart_reg_pkg::*; #(
    parameter logic [15:0] CLOCK_DIV  = 16'd26,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        dividerStage1,
    output logic [3:0]  address,
    output logic        read,
    input  logic [31:0] readData,
    output logic        write,
    output logic [31:0] writeData,
    input  logic        waitrequest,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        cfg_done,
    output logic        rx_overflow
);
    state_e state_q;
    logic [3:0] address_q;
    logic read_q, write_q, cfg_done_q, ovf_q;
    logic [31:0] wdata_q;
    logic [1:0] flags_q;
    logic [7:0] tx_head, tx_wdata;
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic done, rx_push, tx_pop, tx_push;
    logic unused_rd;
    assign unused_rd   = ^readData[31:8];
    assign address     = address_q;
    assign read        = read_q;
    assign write       = write_q;
    assign writeData   = wdata_q;
    assign cfg_done    = cfg_done_q;
    assign rx_overflow = ovf_q;
    assign tx_ready    = ~tx_full;
    assign rx_valid    = ~rx_empty;
    assign done        = (read_q | write_q) & ~waitrequest;
    assign rx_push     = done && state_q == RXRD;
    assign tx_pop      = done && state_q == TXWR;
`ifdef UART_REG_INITIATOR_ECHO_EN
    logic echo;
    assign echo     = rx_push & ~rx_full & ~tx_valid & ~tx_full;
    assign tx_push  = tx_valid | echo;
    assign tx_wdata = tx_valid ? tx_data : readData[7:0];
`else
    assign tx_push  = tx_valid;
    assign tx_wdata = tx_data;
`endif
    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_ni(dividerStage1), .push_i(rx_push), .data_i(readData[7:0]),
        .pop_i(rx_ready), .data_o(rx_data), .empty_o(rx_empty), .full_o(rx_full)
    );
    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_ni(dividerStage1), .push_i(tx_push), .data_i(tx_wdata),
        .pop_i(tx_pop), .data_o(tx_head), .empty_o(tx_empty), .full_o(tx_full)
    );
    // Each completing access loads the strobes for the next state, so POLL-DECIDE-access is 3 cycles.
    always_ff @(posedge clk or negedge dividerStage1) begin
        if (!dividerStage1) begin
            state_q    <= INIT;
            address_q  <= UART_ADDR_FLAGS;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            cfg_done_q <= 1'b0;
            ovf_q      <= 1'b0;
            flags_q    <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    if (!write_q) begin
                        write_q   <= 1'b1;
                        address_q <= UART_ADDR_DIV;
                        wdata_q   <= {16'b0, CLOCK_DIV};
                    end else if (done) begin
                        write_q    <= 1'b0;
                        read_q     <= 1'b1;
                        address_q  <= UART_ADDR_FLAGS;
                        cfg_done_q <= 1'b1;
                        state_q    <= POLL;
                    end
                end
                POLL: begin
                    if (done) begin
                        read_q  <= 1'b0;
                        flags_q <= readData[1:0];
                        state_q <= DECIDE;
                    end
                end
                DECIDE: begin
                    if (flags_q[FLAG_RX_READY]) begin
                        read_q    <= 1'b1;
                        address_q <= UART_ADDR_DATA;
                        state_q   <= RXRD;
                    end else if (flags_q[FLAG_TX_READY] && !tx_empty) begin
                        write_q   <= 1'b1;
                        address_q <= UART_ADDR_DATA;
                        wdata_q   <= {24'b0, tx_head};
                        state_q   <= TXWR;
                    end else begin
                        read_q    <= 1'b1;
                        address_q <= UART_ADDR_FLAGS;
                        state_q   <= POLL;
                    end
                end
                RXRD: begin
                    if (done) begin
                        if (rx_full) ovf_q <= 1'b1;
                        address_q <= UART_ADDR_FLAGS;
                        state_q   <= POLL;
                    end
                end
                TXWR: begin
                    if (done) begin
                        write_q   <= 1'b0;
                        read_q    <= 1'b1;
                        address_q <= UART_ADDR_FLAGS;
                        state_q   <= POLL;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end
endmodule
